sprite_line_scheduler: RTL

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_line_scheduler_if.sv | 29 ++
 rtl/sprite_line_buffer.sv | 46 ++++
 rtl/sprite_line_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared timing constants and types for the sprite line scheduler.
// Sprite geometry defaults here are also used as the scheduler's parameter defaults.
package sprite_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_TOTAL   = 800;
   localparam int unsigned V_TOTAL   = 525;
   localparam int unsigned SPR_DIM   = 30;
   localparam int unsigned HALF      = SPR_DIM / 2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StDone = 2'd2
   } state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] id;
      logic [9:0] x;
      logic [9:0] row_off;
   } entry_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Pixel-timing, sprite-descriptor and pixel-output bundle of the sprite line scheduler.
// master = VGA/game side, slave = scheduler.
interface sprite_line_scheduler_if #(
   parameter int unsigned NUM_SPR = 8,
   parameter int unsigned ROM_AW  = 10
);

   logic [9:0]           DrawX;
   logic [9:0]           DrawY;
   logic                 blank;
   logic [NUM_SPR*10-1:0] spr_x;
   logic [NUM_SPR*10-1:0] spr_y;
   logic [NUM_SPR-1:0]    spr_en;
   logic [ROM_AW-1:0]     rom_address;
   logic [2:0]            spr_id;
   logic                  spr_hit;
   logic                  line_overflow;

   modport master (
      output DrawX, DrawY, blank, spr_x, spr_y, spr_en,
      input  rom_address, spr_id, spr_hit, line_overflow
   );

   modport slave (
      input  DrawX, DrawY, blank, spr_x, spr_y, spr_en,
      output rom_address, spr_id, spr_hit, line_overflow
   );

endinterface

// File: rtl/sprite_line_buffer.sv
// Double-buffered active sprite list: the back list fills during hblank while the
// front list drives the current line; swap copies back to front.
module sprite_line_buffer
   import sprite_pkg::*;
#(
   parameter int unsigned MAX_PER_LINE = 4
) (
   input  logic                        vga_clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        append,
   input  logic                        swap,
   input  entry_t                      app_entry,
   output entry_t [MAX_PER_LINE-1:0]   front,
   output logic                        full
);

   localparam int unsigned CntW = $clog2(MAX_PER_LINE + 1);

   entry_t [MAX_PER_LINE-1:0] back_q;
   entry_t [MAX_PER_LINE-1:0] front_q;
   logic   [CntW-1:0]         cnt_q;

   assign full  = (cnt_q == CntW'(MAX_PER_LINE));
   assign front = front_q;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         back_q  <= '0;
         front_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (clear) begin
            back_q <= '0;
            cnt_q  <= '0;
         end else if (append && !full) begin
            back_q[cnt_q] <= app_entry;
            cnt_q         <= cnt_q + CntW'(1);
         end
         if (swap) begin
            front_q <= back_q;
         end
      end
   end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans descriptors during hblank into an active list,
// then resolves the winning sprite and its shared-ROM address for every pixel.
module sprite_line_scheduler #(
   parameter int unsigned NUM_SPR      = 8,
   parameter int unsigned MAX_PER_LINE = 4,
   parameter int unsigned SPR_DIM      = sprite_pkg::SPR_DIM,
   parameter int unsigned ROM_AW       = 10
) (
   input logic                    vga_clk,
   input logic                    reset,
   sprite_line_scheduler_if.slave bus
);

   import sprite_pkg::*;

   localparam int unsigned SprHalf = SPR_DIM / 2;

   state_e     state_q;
   logic [9:0] line_q;
   logic [2:0] idx_q;
   logic       ovf_q;

   logic       start, scan_last, swap, clear_back, append, full, scan_hit;
   logic [9:0] cur_x, cur_y;
   logic [10:0] dy;
   entry_t     app_entry;
   entry_t [MAX_PER_LINE-1:0] front;

   logic              win_hit;
   logic [2:0]        win_id;
   logic [ROM_AW-1:0] win_addr;
   logic [10:0]       dx;

   assign start      = (state_q == StIdle) && (bus.DrawX == 10'(H_VISIBLE));
   assign scan_last  = (idx_q == 3'(NUM_SPR - 1));
   assign swap       = (state_q == StDone) && (bus.DrawX == 10'(H_TOTAL - 1));
   assign clear_back = start;

   // Signed 11-bit vertical offset of the target line into descriptor idx_q.
   always_comb begin
      cur_x    = bus.spr_x[int'(idx_q)*10 +: 10];
      cur_y    = bus.spr_y[int'(idx_q)*10 +: 10];
      dy       = {1'b0, line_q} + 11'(SprHalf) - {1'b0, cur_y};
      scan_hit = bus.spr_en[idx_q] && !dy[10] && (dy < 11'(SPR_DIM));
      append   = (state_q == StScan) && scan_hit;
      app_entry.valid   = 1'b1;
      app_entry.id      = idx_q;
      app_entry.x       = cur_x;
      app_entry.row_off = 10'(dy * SPR_DIM);
   end

   sprite_line_buffer #(
      .MAX_PER_LINE (MAX_PER_LINE)
   ) u_buf (
      .vga_clk   (vga_clk),
      .reset     (reset),
      .clear     (clear_back),
      .append    (append),
      .swap      (swap),
      .app_entry (app_entry),
      .front     (front),
      .full      (full)
   );

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         line_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  line_q  <= (bus.DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : bus.DrawY + 10'd1;
                  idx_q   <= '0;
                  state_q <= StScan;
               end
            end
            StScan: begin
               idx_q <= idx_q + 3'd1;
               if (scan_last) state_q <= StDone;
            end
            StDone: begin
               if (swap) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         if (bus.DrawY == 10'd0 && bus.DrawX == 10'd0) ovf_q <= 1'b0;
         if (append && full) ovf_q <= 1'b1;
      end
   end

   assign bus.line_overflow = ovf_q;

   // Walk slots high to low so the lowest covering slot is the one left standing.
   always_comb begin
      win_hit  = 1'b0;
      win_id   = '0;
      win_addr = '0;
      dx       = '0;
      for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
         dx = {1'b0, bus.DrawX} + 11'(SprHalf) - {1'b0, front[i].x};
         if (front[i].valid && !dx[10] && (dx < 11'(SPR_DIM))) begin
            win_hit  = 1'b1;
            win_id   = front[i].id;
            win_addr = ROM_AW'(dx + {1'b0, front[i].row_off});
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         bus.rom_address <= '0;
         bus.spr_id      <= '0;
         bus.spr_hit     <= 1'b0;
      end else if (bus.blank && win_hit) begin
         bus.rom_address <= win_addr;
         bus.spr_id      <= win_id;
         bus.spr_hit     <= 1'b1;
      end else begin
         bus.rom_address <= '0;
         bus.spr_id      <= '0;
         bus.spr_hit     <= 1'b0;
      end
   end

endmodule
